// File: rtl/jelly_axi4l_slave_ram_model.sv
// rtl/jelly_axi4l_slave_ram_model.sv - AXI4-Lite slave backed by a word RAM with latency and LFSR ready stalls
module jelly_axi4l_slave_ram_model #(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter int          MEM_SIZE      = 1024,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1,
  parameter int          BUSY_RATE     = 0,
  parameter logic [15:0] SEED          = 16'h1234
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi4l_awaddr,
  input  logic                    s_axi4l_awvalid,
  output logic                    s_axi4l_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi4l_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi4l_wstrb,
  input  logic                    s_axi4l_wvalid,
  output logic                    s_axi4l_wready,
  output logic [1:0]              s_axi4l_bresp,
  output logic                    s_axi4l_bvalid,
  input  logic                    s_axi4l_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi4l_araddr,
  input  logic                    s_axi4l_arvalid,
  output logic                    s_axi4l_arready,
  output logic [DATA_WIDTH-1:0]   s_axi4l_rdata,
  output logic [1:0]              s_axi4l_rresp,
  output logic                    s_axi4l_rvalid,
  input  logic                    s_axi4l_rready
);

  localparam int          STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int          WORD_SEL    = $clog2(STRB_WIDTH);
  localparam int          IDX_WIDTH   = ADDR_WIDTH - WORD_SEL;
  localparam int          MEM_AW      = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [63:0] MEM_LIMIT   = 64'(MEM_SIZE);
  localparam logic [8:0]  BUSY_TH     = 9'(BUSY_RATE);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'd0) ? 16'd1 : s;
  endfunction

  // lane 0 = AW, 1 = W, 2 = AR
  localparam logic [2:0][15:0] LFSR_INIT = {fix_seed(SEED ^ 16'hFF00), fix_seed(SEED ^ 16'h00FF), fix_seed(SEED)};

  logic [2:0][15:0] lfsr;
  logic [2:0]       busy;
  logic             run;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr <= LFSR_INIT;
      busy <= '0;
      run  <= 1'b0;
    end else begin
      run <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        lfsr[i] <= {lfsr[i][14:0], lfsr[i][15] ^ lfsr[i][13] ^ lfsr[i][12] ^ lfsr[i][10]};
        busy[i] <= {1'b0, lfsr[i][7:0]} < BUSY_TH;
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

  wr_state_t             wr_state, wr_state_next;
  logic                  aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [15:0]           wr_cnt;
  logic [1:0]            bresp;
  logic [IDX_WIDTH-1:0]  aw_idx;
  logic                  aw_in_range;
  logic                  aw_hs, w_hs, b_hs, wr_commit;

  assign s_axi4l_awready = run & (wr_state == WR_IDLE) & ~aw_full & ~busy[0];
  assign s_axi4l_wready  = run & (wr_state == WR_IDLE) & ~w_full & ~busy[1];
  assign s_axi4l_bvalid  = (wr_state == WR_RESP);
  assign s_axi4l_bresp   = bresp;

  assign aw_hs       = s_axi4l_awready & s_axi4l_awvalid;
  assign w_hs        = s_axi4l_wready & s_axi4l_wvalid;
  assign b_hs        = s_axi4l_bvalid & s_axi4l_bready;
  assign wr_commit   = (wr_state == WR_IDLE) & aw_full & w_full;
  assign aw_idx      = aw_addr[ADDR_WIDTH-1:WORD_SEL];
  assign aw_in_range = 64'(aw_idx) < MEM_LIMIT;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wr_state <= WR_IDLE;
    else          wr_state <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_commit)        wr_state_next = WR_WAIT;
      WR_WAIT: if (wr_cnt == 16'd0)  wr_state_next = WR_RESP;
      WR_RESP: if (s_axi4l_bready)   wr_state_next = WR_IDLE;
      default:                       wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      wr_cnt  <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi4l_awaddr;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axi4l_wdata;
        w_strb <= s_axi4l_wstrb;
      end
      if (wr_commit) begin
        bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        wr_cnt <= 16'(WRITE_LATENCY);
      end else if (wr_state == WR_WAIT && wr_cnt != 16'd0) begin
        wr_cnt <= wr_cnt - 16'd1;
      end
      if (b_hs) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
    end
  end

  // RAM survives reset, so it lives outside the reset domain
  always_ff @(posedge aclk) begin
    if (wr_commit && aw_in_range) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (w_strb[i]) mem[aw_idx[MEM_AW-1:0]][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  rd_state_t             rd_state, rd_state_next;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [15:0]           rd_cnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic [IDX_WIDTH-1:0]  ar_idx;
  logic                  ar_in_range;
  logic                  ar_hs;

  assign s_axi4l_arready = run & (rd_state == RD_IDLE) & ~busy[2];
  assign s_axi4l_rvalid  = (rd_state == RD_RESP);
  assign s_axi4l_rdata   = rdata;
  assign s_axi4l_rresp   = rresp;

  assign ar_hs       = s_axi4l_arready & s_axi4l_arvalid;
  assign ar_idx      = ar_addr[ADDR_WIDTH-1:WORD_SEL];
  assign ar_in_range = 64'(ar_idx) < MEM_LIMIT;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_state <= RD_IDLE;
    else          rd_state <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs)           rd_state_next = RD_WAIT;
      RD_WAIT: if (rd_cnt == 16'd0) rd_state_next = RD_RESP;
      RD_RESP: if (s_axi4l_rready)  rd_state_next = RD_IDLE;
      default:                      rd_state_next = RD_IDLE;
    endcase
  end

  // rdata samples the pre-commit word when a write lands on the same edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_addr <= '0;
      rd_cnt  <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else if (ar_hs) begin
      ar_addr <= s_axi4l_araddr;
      rd_cnt  <= 16'(READ_LATENCY);
    end else if (rd_state == RD_WAIT) begin
      if (rd_cnt == 16'd0) begin
        rdata <= ar_in_range ? mem[ar_idx[MEM_AW-1:0]] : '0;
        rresp <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        rd_cnt <= rd_cnt - 16'd1;
      end
    end
  end

  logic unused_addr;
  assign unused_addr = ^{aw_addr, ar_addr};

endmodule

// File: tb/tb_jelly_axi4l_slave_ram_model.sv
// tb/tb_jelly_axi4l_slave_ram_model.sv - randomized scoreboard bench for the AXI4-Lite RAM model
module tb_jelly_axi4l_slave_ram_model;

  localparam int RL = 2;
  localparam int WL = 1;
  localparam int MEM_SIZE = 1024;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_axi4l_awaddr;
  logic        s_axi4l_awvalid;
  logic        s_axi4l_awready;
  logic [31:0] s_axi4l_wdata;
  logic [3:0]  s_axi4l_wstrb;
  logic        s_axi4l_wvalid;
  logic        s_axi4l_wready;
  logic [1:0]  s_axi4l_bresp;
  logic        s_axi4l_bvalid;
  logic        s_axi4l_bready;
  logic [31:0] s_axi4l_araddr;
  logic        s_axi4l_arvalid;
  logic        s_axi4l_arready;
  logic [31:0] s_axi4l_rdata;
  logic [1:0]  s_axi4l_rresp;
  logic        s_axi4l_rvalid;
  logic        s_axi4l_rready;

  jelly_axi4l_slave_ram_model #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MEM_SIZE),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL), .BUSY_RATE(128), .SEED(16'h1234)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi4l_awaddr(s_axi4l_awaddr), .s_axi4l_awvalid(s_axi4l_awvalid), .s_axi4l_awready(s_axi4l_awready),
    .s_axi4l_wdata(s_axi4l_wdata), .s_axi4l_wstrb(s_axi4l_wstrb), .s_axi4l_wvalid(s_axi4l_wvalid),
    .s_axi4l_wready(s_axi4l_wready), .s_axi4l_bresp(s_axi4l_bresp), .s_axi4l_bvalid(s_axi4l_bvalid),
    .s_axi4l_bready(s_axi4l_bready), .s_axi4l_araddr(s_axi4l_araddr), .s_axi4l_arvalid(s_axi4l_arvalid),
    .s_axi4l_arready(s_axi4l_arready), .s_axi4l_rdata(s_axi4l_rdata), .s_axi4l_rresp(s_axi4l_rresp),
    .s_axi4l_rvalid(s_axi4l_rvalid), .s_axi4l_rready(s_axi4l_rready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int wr_later;
  int wr_issued = 0, rd_issued = 0, b_cnt = 0, r_cnt = 0;
  int aw_stall = 0, aw_acc = 0, ar_stall = 0, ar_acc = 0;
  logic [31:0] ref_mem [16];

  always @(posedge aclk) begin
    if (aresetn && s_axi4l_bvalid && s_axi4l_bready) b_cnt++;
    if (aresetn && s_axi4l_rvalid && s_axi4l_rready) r_cnt++;
  end

  always @(negedge aclk) begin
    if (s_axi4l_awvalid) begin
      if (s_axi4l_awready) aw_acc++; else aw_stall++;
    end
    if (s_axi4l_arvalid) begin
      if (s_axi4l_arready) ar_acc++; else ar_stall++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // each sender returns at the negedge right after its handshake edge, hs = that edge's number
  task automatic send_aw(input logic [31:0] a, input int dly, output int hs);
    int n;
    n = 0;
    repeat (dly + 1) @(negedge aclk);
    s_axi4l_awaddr = a;
    s_axi4l_awvalid = 1'b1;
    while (!s_axi4l_awready && n < 200) begin @(negedge aclk); n++; end
    check("aw_accept", s_axi4l_awready, 1);
    hs = cyc + 1;
    @(negedge aclk);
    s_axi4l_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly, output int hs);
    int n;
    n = 0;
    repeat (dly + 1) @(negedge aclk);
    s_axi4l_wdata = d;
    s_axi4l_wstrb = s;
    s_axi4l_wvalid = 1'b1;
    while (!s_axi4l_wready && n < 200) begin @(negedge aclk); n++; end
    check("w_accept", s_axi4l_wready, 1);
    hs = cyc + 1;
    @(negedge aclk);
    s_axi4l_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input int dly, output int hs);
    int n;
    n = 0;
    repeat (dly + 1) @(negedge aclk);
    s_axi4l_araddr = a;
    s_axi4l_arvalid = 1'b1;
    while (!s_axi4l_arready && n < 200) begin @(negedge aclk); n++; end
    check("ar_accept", s_axi4l_arready, 1);
    hs = cyc + 1;
    @(negedge aclk);
    s_axi4l_arvalid = 1'b0;
  endtask

  task automatic wait_bvalid(output int c);
    int n;
    n = 0;
    while (!s_axi4l_bvalid && n < 64) begin @(negedge aclk); n++; end
    check("b_seen", s_axi4l_bvalid, 1);
    c = cyc;
  endtask

  task automatic wait_rvalid(output int c);
    int n;
    n = 0;
    while (!s_axi4l_rvalid && n < 64) begin @(negedge aclk); n++; end
    check("r_seen", s_axi4l_rvalid, 1);
    c = cyc;
  endtask

  task automatic hold_b(input logic [1:0] exp_resp, input int hold);
    check("bresp", s_axi4l_bresp, exp_resp);
    repeat (hold) begin
      @(negedge aclk);
      check("b_hold_valid", s_axi4l_bvalid, 1);
      check("b_hold_resp", s_axi4l_bresp, exp_resp);
      check("b_hold_awready", s_axi4l_awready, 0);
      check("b_hold_wready", s_axi4l_wready, 0);
    end
    s_axi4l_bready = 1'b1;
    @(negedge aclk);
    s_axi4l_bready = 1'b0;
    check("b_drop", s_axi4l_bvalid, 0);
  endtask

  task automatic hold_r(input logic [31:0] exp_d, input logic [1:0] exp_resp, input int hold);
    check("rdata", s_axi4l_rdata, exp_d);
    check("rresp", s_axi4l_rresp, exp_resp);
    repeat (hold) begin
      @(negedge aclk);
      check("r_hold_valid", s_axi4l_rvalid, 1);
      check("r_hold_data", s_axi4l_rdata, exp_d);
      check("r_hold_resp", s_axi4l_rresp, exp_resp);
      check("r_hold_arready", s_axi4l_arready, 0);
    end
    s_axi4l_rready = 1'b1;
    @(negedge aclk);
    s_axi4l_rready = 1'b0;
    check("r_drop", s_axi4l_rvalid, 0);
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                           input int dly_aw, input int dly_w, input int hold);
    int ha, hw, later, bc, idx;
    idx = int'(addr >> 2);
    fork
      send_aw(addr, dly_aw, ha);
      send_w(d, s, dly_w, hw);
    join
    later = (ha > hw) ? ha : hw;
    wr_later = later;
    wr_issued++;
    wait_bvalid(bc);
    check("b_latency", bc, later + 2 + WL);
    hold_b((idx < MEM_SIZE) ? 2'b00 : 2'b10, hold);
    if (idx < 16) ref_mem[idx] = merge(ref_mem[idx], d, s);
  endtask

  task automatic read_txn(input logic [31:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_resp,
                          input int dly, input int hold);
    int ha, rc;
    send_ar(addr, dly, ha);
    rd_issued++;
    wait_rvalid(rc);
    check("r_latency", rc, ha + 1 + RL);
    hold_r(exp_d, exp_resp, hold);
  endtask

  task automatic pulse_reset_and_watch();
    #2 aresetn = 1'b0;
    #1;
    check("rst_awready", s_axi4l_awready, 0);
    check("rst_wready", s_axi4l_wready, 0);
    check("rst_arready", s_axi4l_arready, 0);
    check("rst_bvalid", s_axi4l_bvalid, 0);
    check("rst_rvalid", s_axi4l_rvalid, 0);
    check("rst_bresp", s_axi4l_bresp, 0);
    check("rst_rresp", s_axi4l_rresp, 0);
    check("rst_rdata", s_axi4l_rdata, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      check("no_stale_b", s_axi4l_bvalid, 0);
      check("no_stale_r", s_axi4l_rvalid, 0);
    end
  endtask

  initial begin
    int wi, ri, ra, rc, ha, hw, bc, sample;
    logic [31:0] wd, old_d, exp_d;
    logic [3:0]  ws;
    logic [1:0]  exp_r;

    aresetn = 1'b0;
    s_axi4l_awaddr = '0; s_axi4l_awvalid = 1'b0;
    s_axi4l_wdata = '0;  s_axi4l_wstrb = '0; s_axi4l_wvalid = 1'b0;
    s_axi4l_bready = 1'b0;
    s_axi4l_araddr = '0; s_axi4l_arvalid = 1'b0;
    s_axi4l_rready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(negedge aclk);
    check("reset_awready", s_axi4l_awready, 0);
    check("reset_wready", s_axi4l_wready, 0);
    check("reset_arready", s_axi4l_arready, 0);
    check("reset_bvalid", s_axi4l_bvalid, 0);
    check("reset_rvalid", s_axi4l_rvalid, 0);
    check("reset_rdata", s_axi4l_rdata, 0);
    aresetn = 1'b1;

    write_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    read_txn(32'h10, 32'hDEADBEEF, 2'b00, 0, 0);
    write_txn(32'h10, 32'h0000CAFE, 4'h3, 3, 0, 4);
    read_txn(32'h10, 32'hDEADCAFE, 2'b00, 0, 0);
    write_txn(32'h0, 32'h11223344, 4'hF, 0, 0, 0);
    write_txn(32'h1000, 32'hFFFFFFFF, 4'hF, 0, 1, 0);
    read_txn(32'h1000, 32'h0, 2'b10, 0, 0);
    read_txn(32'h0, 32'h11223344, 2'b00, 0, 0);
    write_txn(32'h14, 32'h55AA00FF, 4'h0, 0, 0, 10);
    read_txn(32'h14, 32'h0, 2'b00, 0, 10);

    for (int i = 0; i < 16; i++) write_txn(32'(i * 4), $urandom, 4'hF, 0, 0, 0);

    for (int it = 0; it < 1000; it++) begin
      wi = ($urandom_range(0, 7) == 0) ? 1024 + int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) ri = wi;
      else ri = ($urandom_range(0, 7) == 0) ? 1024 + int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      old_d = (ri < 16) ? ref_mem[ri] : 32'h0;
      wr_later = 32'h3FFF_FFFF;
      fork
        write_txn(32'(wi * 4) + $urandom_range(0, 3), wd, ws,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        begin
          send_ar(32'(ri * 4) + $urandom_range(0, 3), $urandom_range(0, 6), ra);
          rd_issued++;
          wait_rvalid(rc);
          sample = ra + 1 + RL;
          check("r_latency", rc, sample);
          if (ri >= MEM_SIZE) begin
            exp_d = 32'h0; exp_r = 2'b10;
          end else begin
            exp_r = 2'b00;
            exp_d = (ri == wi && wr_later + 1 < sample) ? merge(old_d, wd, ws) : old_d;
          end
          hold_r(exp_d, exp_r, $urandom_range(0, 3));
        end
      join
    end

    check("aw_stalls_seen", aw_stall > 0, 1);
    check("aw_accepts_seen", aw_acc > 0, 1);
    check("ar_stalls_seen", ar_stall > 0, 1);
    check("ar_accepts_seen", ar_acc > 0, 1);
    check("b_count", b_cnt, wr_issued);
    check("r_count", r_cnt, rd_issued);

    write_txn(32'h14, 32'h0BADF00D, 4'hF, 0, 0, 0);
    send_ar(32'h14, 0, ha);
    pulse_reset_and_watch();

    fork
      send_aw(32'h18, 0, ha);
      send_w(32'hA5A55A5A, 4'hF, 0, hw);
    join
    wait_bvalid(bc);
    pulse_reset_and_watch();
    ref_mem[6] = 32'hA5A55A5A;

    read_txn(32'h18, 32'hA5A55A5A, 2'b00, 0, 0);
    read_txn(32'h14, 32'h0BADF00D, 2'b00, 0, 0);
    read_txn(32'h4, ref_mem[1], 2'b00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jelly_axi4l_slave_ram_model.md
Name: jelly_axi4l_slave_ram_model

Overview:
Parametrised AXI4-Lite slave backed by an internal word RAM, with programmable response latency, pseudo-random ready stalls and out-of-range error responses. It is the AXI4-Lite counterpart of the AXI4 memory model used in the block-design simulation stand-ins, and sits on m_axi4l_peri-style buses to exercise peripheral masters. It handles one outstanding write and one outstanding read, which proceed concurrently.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, data width; power of two, >=8.
MEM_SIZE, 1024, RAM depth in words.
READ_LATENCY, 2, extra cycles between AR handshake and rvalid (0 allowed).
WRITE_LATENCY, 1, extra cycles between write commit and bvalid (0 allowed).
BUSY_RATE, 0, 0..255; a ready is suppressed in a cycle when lfsr[7:0] < BUSY_RATE.
SEED, 16'h1234, LFSR seed; 0 is replaced by 1.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axi4l_awaddr  in  ADDR_WIDTH  write address
s_axi4l_awvalid  in  1  AW valid
s_axi4l_awready  out  1  AW ready
s_axi4l_wdata  in  DATA_WIDTH  write data
s_axi4l_wstrb  in  DATA_WIDTH/8  byte enables
s_axi4l_wvalid  in  1  W valid
s_axi4l_wready  out  1  W ready
s_axi4l_bresp  out  2  write response
s_axi4l_bvalid  out  1  B valid
s_axi4l_bready  in  1  B ready
s_axi4l_araddr  in  ADDR_WIDTH  read address
s_axi4l_arvalid  in  1  AR valid
s_axi4l_arready  out  1  AR ready
s_axi4l_rdata  out  DATA_WIDTH  read data
s_axi4l_rresp  out  2  read response
s_axi4l_rvalid  out  1  R valid
s_axi4l_rready  in  1  R ready

Behaviour:
- Reset (aresetn low, asynchronous): all ready and valid outputs 0; bresp, rresp and rdata 0; FSMs idle; AW/W slots empty; LFSRs reloaded with SEED. RAM contents are not cleared; they are zero at time 0 and preserved across reset. Readies may first rise in the cycle after release.
- Word index is addr >> log2(DATA_WIDTH/8); the low address bits are ignored. An index >= MEM_SIZE is out of range.
- Stalls: three independent 16-bit Fibonacci LFSRs (x^16+x^14+x^13+x^11), one each for AW, W and AR, seeded SEED, SEED^16'h00FF and SEED^16'hFF00. Each LFSR advances every cycle. busy_x is a register. With BUSY_RATE=0 a channel is never busy.
- Every ready is driven from registers only; there is no combinational path from any input to any output.
- Write FSM, WR_IDLE -> WR_WAIT -> WR_RESP:
  - In WR_IDLE: awready = ~aw_full & ~busy_aw; wready = ~w_full & ~busy_w. AW and W may handshake in either order or in the same cycle, and each is captured into its slot.
  - Once both slots are full, the next cycle is the commit cycle. An in-range word is written byte-wise per wstrb, and wstrb=0 writes nothing. The response is OKAY (00) in range and SLVERR (10) out of range.
  - After commit the FSM waits WRITE_LATENCY cycles, then sets bvalid, so bvalid is high 2+WRITE_LATENCY cycles after the later handshake. bvalid and bresp stay stable until bready.
  - On B handshake: slots are cleared and the FSM returns to WR_IDLE. awready/wready stay 0 from slot-full until that return.
- Read FSM, RD_IDLE -> RD_WAIT -> RD_RESP:
  - In RD_IDLE: arready = ~busy_ar. The AR handshake at edge T captures the address.
  - rvalid rises at edge T+1+READ_LATENCY. rdata is sampled from RAM on that edge; out-of-range returns rdata=0, rresp=SLVERR.
  - rvalid, rdata and rresp are held until rready, then the FSM returns to RD_IDLE.
- Read/write collision: if a write commits on the same edge that rdata is sampled for the same word, the read returns pre-write data (read-first).
- Write and read paths are fully independent; simultaneous AW, W and AR handshakes in one cycle are legal.
- Reset mid-transaction: the transaction is discarded with no B/R beat afterwards. A write whose commit edge has already passed remains in RAM.

Test Plan:
- BUSY_RATE=0, WRITE_LATENCY=1: AW 0x10 and W 0xDEADBEEF with strb 0xF in the same cycle T -> bvalid at T+3, bresp=00; then AR 0x10 at U with READ_LATENCY=2 -> rvalid at U+3, rdata=0xDEADBEEF, rresp=00.
- W handshake 3 cycles before AW; strb 0x3, data 0x0000CAFE over a word holding 0xDEADBEEF -> read-back 0xDEADCAFE; awready/wready stay 0 until bready.
- MEM_SIZE=1024: write/read address 0x1000 -> bresp=10, rdata=0, rresp=10; word 0 unchanged.
- bready/rready held 0 for 10 cycles -> bvalid, rvalid and payload stable; no new AW/W/AR accepted.
- BUSY_RATE=128, 1000 random transactions against a scoreboard -> all data match, readies toggle, no lost or duplicated responses; fixed SEED gives the identical ready pattern across reruns.
- aresetn pulsed low in RD_WAIT and in WR_RESP -> all outputs 0 asynchronously, no stale rvalid/bvalid after release, previously committed data still readable.
